// File: rtl/seg14_pkg.sv
// Shared constants and types for the 14-segment scan driver.
// Glyphs are active-high; segment a is bit 0, g1 is bit 6, g2 is bit 7.
package seg14_pkg;

   localparam logic [13:0] GLYPH_0 = 14'h003F;
   localparam logic [13:0] GLYPH_1 = 14'h0006;
   localparam logic [13:0] GLYPH_2 = 14'h00DB;
   localparam logic [13:0] GLYPH_3 = 14'h00CF;
   localparam logic [13:0] GLYPH_4 = 14'h00E6;
   localparam logic [13:0] GLYPH_5 = 14'h00ED;
   localparam logic [13:0] GLYPH_6 = 14'h00FD;
   localparam logic [13:0] GLYPH_7 = 14'h0007;
   localparam logic [13:0] GLYPH_8 = 14'h00FF;
   localparam logic [13:0] GLYPH_9 = 14'h00EF;
   localparam logic [13:0] GLYPH_A = 14'h00F7;
   localparam logic [13:0] GLYPH_B = 14'h128F;
   localparam logic [13:0] GLYPH_C = 14'h0039;
   localparam logic [13:0] GLYPH_D = 14'h120F;
   localparam logic [13:0] GLYPH_E = 14'h0079;
   localparam logic [13:0] GLYPH_F = 14'h0071;

   localparam logic [13:0] GLYPH_BLANK = 14'h0000;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

endpackage

// File: rtl/seg14_decoder.sv
// Hex nibble to active-high 14-segment glyph lookup.
module seg14_decoder
   import seg14_pkg::*;
(
   input  logic [3:0]  hex,
   output logic [13:0] glyph
);

   always_comb begin
      glyph = GLYPH_BLANK;
      case (hex)
         4'h0: glyph = GLYPH_0;
         4'h1: glyph = GLYPH_1;
         4'h2: glyph = GLYPH_2;
         4'h3: glyph = GLYPH_3;
         4'h4: glyph = GLYPH_4;
         4'h5: glyph = GLYPH_5;
         4'h6: glyph = GLYPH_6;
         4'h7: glyph = GLYPH_7;
         4'h8: glyph = GLYPH_8;
         4'h9: glyph = GLYPH_9;
         4'hA: glyph = GLYPH_A;
         4'hB: glyph = GLYPH_B;
         4'hC: glyph = GLYPH_C;
         4'hD: glyph = GLYPH_D;
         4'hE: glyph = GLYPH_E;
         4'hF: glyph = GLYPH_F;
         default: glyph = GLYPH_BLANK;
      endcase
   end

endmodule

// File: rtl/seg14_scan_driver.sv
// Time-multiplexed common-anode 14-segment driver with blanking guard,
// frame-synchronous data commit and leading-zero blanking.
module seg14_scan_driver
   import seg14_pkg::*;
#(
   parameter int DWELL_CYCLES = 40000,
   parameter int BLANK_CYCLES = 400,
   parameter int CNT_W        = 16
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] load_data,
   input  logic [3:0]  load_dp,
   input  logic        lzb_en,
   output logic [14:0] seg_out,
   output logic [3:0]  digit_en,
   output logic        frame_done
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [13:0]      SEG_OFF    = 14'h3FFF;

   scan_state_t      state, state_nxt;
   logic [1:0]       idx, idx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [15:0] act_data, pend_data;
   logic [3:0]  act_dp, pend_dp;
   logic        pend_full, pend_full_nxt;
   logic        load_fire, commit;

   logic [3:0]  digit_hex;
   logic [13:0] glyph;
   logic        digit_blank;
   logic        zero3, zero2, zero1;
   logic [14:0] seg_nxt;
   logic [3:0]  en_nxt;
   logic        frame_done_nxt;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt + CNT_W'(1);
      case (state)
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_nxt = SHOW;
               cnt_nxt   = '0;
            end
         end
         SHOW: begin
            if (cnt == DWELL_LAST) begin
               state_nxt = BLANK;
               cnt_nxt   = '0;
               idx_nxt   = idx + 2'd1;
            end
         end
         default: begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are computed for the upcoming cycle so the registers track the state exactly.
   always_comb begin
      zero3     = (act_data[15:12] == 4'h0);
      zero2     = (act_data[11:8]  == 4'h0);
      zero1     = (act_data[7:4]   == 4'h0);
      digit_hex = act_data[3:0];
      digit_blank = 1'b0;
      case (idx_nxt)
         2'd1: begin
            digit_hex   = act_data[7:4];
            digit_blank = lzb_en & zero3 & zero2 & zero1;
         end
         2'd2: begin
            digit_hex   = act_data[11:8];
            digit_blank = lzb_en & zero3 & zero2;
         end
         2'd3: begin
            digit_hex   = act_data[15:12];
            digit_blank = lzb_en & zero3;
         end
         default: begin
            digit_hex   = act_data[3:0];
            digit_blank = 1'b0;
         end
      endcase
   end

   seg14_decoder u_decoder (
      .hex   (digit_hex),
      .glyph (glyph)
   );

   always_comb begin
      en_nxt  = 4'hF;
      seg_nxt = {1'b1, SEG_OFF};
      if (state_nxt == SHOW) begin
         en_nxt[idx_nxt] = 1'b0;
         seg_nxt = {~act_dp[idx_nxt], (digit_blank ? SEG_OFF : ~glyph)};
      end
      frame_done_nxt = (state_nxt == SHOW) && (idx_nxt == 2'd3) && (cnt_nxt == DWELL_LAST);
   end

   // A load can never coincide with a commit: commit needs pending full, which holds ready low.
   assign load_fire     = load_valid & load_ready;
   assign commit        = frame_done & pend_full;
   assign pend_full_nxt = load_fire ? 1'b1 : (commit ? 1'b0 : pend_full);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= BLANK;
         idx        <= 2'd0;
         cnt        <= '0;
         act_data   <= 16'h0000;
         act_dp     <= 4'h0;
         pend_data  <= 16'h0000;
         pend_dp    <= 4'h0;
         pend_full  <= 1'b0;
         load_ready <= 1'b1;
         seg_out    <= 15'h7FFF;
         digit_en   <= 4'hF;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         cnt        <= cnt_nxt;
         if (load_fire) begin
            pend_data <= load_data;
            pend_dp   <= load_dp;
         end
         if (commit) begin
            act_data <= pend_data;
            act_dp   <= pend_dp;
         end
         pend_full  <= pend_full_nxt;
         load_ready <= ~pend_full_nxt;
         seg_out    <= seg_nxt;
         digit_en   <= en_nxt;
         frame_done <= frame_done_nxt;
      end
   end

endmodule
